// File: rtl/vga_scanout.sv
// VGA raster engine: 640x480@60 timing over a 160x120 framebuffer.
// Pixel coordinates issue at stage 0; palette RGB and syncs land at stage 2.
module vga_scanout #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter bit SYNC_POL = 1'b0
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  output logic [7:0]  o_pxlX,
  output logic [7:0]  o_pxlY,
  input  logic [3:0]  i_value,
  input  logic        i_palWe,
  input  logic [3:0]  i_palIdx,
  input  logic [11:0] i_palData,
  output logic [3:0]  o_red,
  output logic [3:0]  o_green,
  output logic [3:0]  o_blue,
  output logic        o_hsync,
  output logic        o_vsync,
  output logic        o_frameStart,
  output logic        o_vblank
);

  localparam logic [9:0] HA   = 10'(H_ACTIVE);
  localparam logic [9:0] HMAX = 10'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
  localparam logic [9:0] HS0  = 10'(H_ACTIVE + H_FP);
  localparam logic [9:0] HS1  = 10'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [9:0] VA   = 10'(V_ACTIVE);
  localparam logic [9:0] VMAX = 10'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);
  localparam logic [9:0] VS0  = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0] VS1  = 10'(V_ACTIVE + V_FP + V_SYNC);

  logic [9:0]  hcount;
  logic [9:0]  vcount;
  logic        act0;
  logic        hs0;
  logic        vs0;
  logic        act1;
  logic        hs1;
  logic        vs1;
  logic [11:0] rgb;
  logic [11:0] pal [16];

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      hcount <= '0;
      vcount <= '0;
    end else if (hcount == HMAX) begin
      hcount <= '0;
      vcount <= (vcount == VMAX) ? '0 : vcount + 10'd1;
    end else begin
      hcount <= hcount + 10'd1;
    end
  end

  // Each framebuffer pixel covers a 4x4 block of screen pixels.
  always_comb begin
    o_pxlX = 8'd0;
    o_pxlY = 8'd0;
    if (hcount < HA) o_pxlX = hcount[9:2];
    if (vcount < VA) o_pxlY = {1'b0, vcount[8:2]};
  end

  assign act0 = (hcount < HA) && (vcount < VA);
  assign hs0  = (hcount >= HS0) && (hcount < HS1);
  assign vs0  = (vcount >= VS0) && (vcount < VS1);

  assign o_frameStart = (hcount == 10'd0) && (vcount == 10'd0);
  assign o_vblank     = (vcount >= VA);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      act1 <= 1'b0;
      hs1  <= 1'b0;
      vs1  <= 1'b0;
    end else begin
      act1 <= act0;
      hs1  <= hs0;
      vs1  <= vs0;
    end
  end

  // Palette read uses the pre-write value when idx collides with a write.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      rgb     <= '0;
      o_hsync <= ~SYNC_POL;
      o_vsync <= ~SYNC_POL;
    end else begin
      rgb     <= act1 ? pal[i_value] : 12'h000;
      o_hsync <= hs1 ? SYNC_POL : ~SYNC_POL;
      o_vsync <= vs1 ? SYNC_POL : ~SYNC_POL;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int k = 0; k < 16; k++) begin
        pal[k] <= {3{4'(k)}};
      end
    end else if (i_palWe) begin
      pal[i_palIdx] <= i_palData;
    end
  end

  assign {o_red, o_green, o_blue} = rgb;

endmodule
